generador_sonido: RTL and testbench
===================================

// Module: generador_sonido
// PURPOSE
//  Consumer of the score-event pulse pulso_sonido. Each rising edge of the
//  pulse starts, or restarts, a fixed-length square-wave beep on the speaker pin.
//  The tone period and the beep length are set by parameters.
//  Sits between the score register and the board buzzer output.
// PARAMETERS
//  HALF_PERIOD  56818       clk cycles per tone half-period (880 Hz at 100 MHz); >=1
//  DUR_CYCLES   10000000    clk cycles per beep (100 ms at 100 MHz); >=1
// PORTS
//  clk           in   1  system clock; all logic on posedge
//  reset         in   1  synchronous, active-high reset
//  pulso_sonido  in   1  trigger level from score logic; may stay high for many cycles
//  bocina        out  1  registered square-wave drive to buzzer
//  sonando       out  1  registered busy flag; high while a beep is playing
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (reset).
//  - Reset values: bocina=0, sonando=0, state=IDLE, all counters=0, pulso_d=0.
//  - Edge detect:
//    - pulso_d <= pulso_sonido every cycle.
//    - rise = pulso_sonido & ~pulso_d.
//    - A level held high counts once.
//    - A level that is high when reset deasserts counts as a rise.
//  - Counter widths: half_cnt is $clog2(HALF_PERIOD)+1 bits; dur_cnt is $clog2(DUR_CYCLES)+1 bits.
//    Both are unsigned and never exceed their parameter minus 1.
//  - State IDLE:
//    - bocina=0, sonando=0, counters held at 0.
//    - On rise: state<=PLAY, bocina<=1, sonando<=1, half_cnt<=0, dur_cnt<=0.
//      Outputs rise at the same edge that samples the rise (latency 1 clk from input change).
//  - State PLAY, tone:
//    - half_cnt increments every cycle.
//    - When half_cnt==HALF_PERIOD-1: half_cnt<=0 and bocina toggles.
//    - Each level lasts exactly HALF_PERIOD cycles.
//  - State PLAY, duration:
//    - dur_cnt increments every cycle.
//    - When dur_cnt==DUR_CYCLES-1 and no rise: state<=IDLE, bocina<=0, sonando<=0.
//    - sonando is therefore high for exactly DUR_CYCLES cycles per single trigger.
//  - Retrigger in PLAY: rise sets dur_cnt<=0 only.
//    - Tone phase (half_cnt, bocina) continues undisturbed, with no glitch.
//    - Rise on the terminal cycle (dur_cnt==DUR_CYCLES-1) wins: PLAY continues with dur_cnt<=0.
//  - Terminal count and tone toggle in the same cycle: end wins; bocina<=0.
//  - Reset mid-PLAY: the next edge forces all reset values; the beep is lost and not resumed.
//  - HALF_PERIOD=1: bocina toggles every cycle in PLAY.
//  - DUR_CYCLES=1: a one-cycle beep with bocina=1.
// TESTING  (HALF_PERIOD=3, DUR_CYCLES=20)
//  1. Hold reset 3 cycles with pulso_sonido toggling -> bocina=0, sonando=0 throughout.
//  2. One-cycle pulse sampled at edge k -> sonando=1 on edges k..k+19, 0 at k+20.
//     bocina reads 111000111000111000 11, then 0.
//  3. pulso_sonido held high 8 cycles -> identical to scenario 2, with no second beep.
//  4. Second pulse 10 cycles after the first -> sonando high for 30 continuous cycles.
//     bocina keeps an exact 3/3 cadence with no phase reset.
//  5. Second pulse on the terminal cycle (dur_cnt=19) -> sonando stays 1, with no one-cycle gap.
//     The beep ends 20 cycles later.
//  6. Reset asserted at dur_cnt=7 -> next edge bocina=0, sonando=0.
//     Trigger held high through reset release -> new beep starts on the first post-reset edge.

Source files
------------

// File: rtl/generador_sonido.sv
// Beep generator: each rising edge of pulso_sonido starts or restarts a
// fixed-length square-wave tone on the buzzer pin.
//
// Ports:
//   clk           system clock, all logic on posedge
//   reset         synchronous, active-high reset
//   pulso_sonido  trigger level from score logic (edge-detected here)
//   bocina        registered square-wave drive to the buzzer
//   sonando       registered busy flag, high while a beep is playing
module generador_sonido #(
    parameter int HALF_PERIOD = 56818,
    parameter int DUR_CYCLES  = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic pulso_sonido,
    output logic bocina,
    output logic sonando
);

    localparam int HW = $clog2(HALF_PERIOD) + 1;
    localparam int DW = $clog2(DUR_CYCLES) + 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
    localparam logic [DW-1:0] DUR_LAST  = DW'(DUR_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t        state, state_n;
    logic [HW-1:0] half_cnt, half_n;
    logic [DW-1:0] dur_cnt, dur_n;
    logic          bocina_n, sonando_n;
    logic          pulso_d;
    logic          rise;

    // pulso_d clears in reset, so a level held through reset release
    // is seen as a fresh rise on the first post-reset edge.
    assign rise = pulso_sonido & ~pulso_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            half_cnt <= '0;
            dur_cnt  <= '0;
            bocina   <= 1'b0;
            sonando  <= 1'b0;
            pulso_d  <= 1'b0;
        end else begin
            state    <= state_n;
            half_cnt <= half_n;
            dur_cnt  <= dur_n;
            bocina   <= bocina_n;
            sonando  <= sonando_n;
            pulso_d  <= pulso_sonido;
        end
    end

    always_comb begin
        state_n   = state;
        half_n    = half_cnt;
        dur_n     = dur_cnt;
        bocina_n  = bocina;
        sonando_n = sonando;

        unique case (state)
            IDLE: begin
                half_n    = '0;
                dur_n     = '0;
                bocina_n  = 1'b0;
                sonando_n = 1'b0;
                if (rise) begin
                    state_n   = PLAY;
                    bocina_n  = 1'b1;
                    sonando_n = 1'b1;
                end
            end

            PLAY: begin
                // Tone phase runs freely; a retrigger never touches it.
                if (half_cnt == HALF_LAST) begin
                    half_n   = '0;
                    bocina_n = ~bocina;
                end else begin
                    half_n = half_cnt + HW'(1);
                end

                // A rise on the terminal cycle extends the beep; otherwise
                // the end overrides any tone toggle in the same cycle.
                if (rise) begin
                    dur_n = '0;
                end else if (dur_cnt == DUR_LAST) begin
                    state_n   = IDLE;
                    half_n    = '0;
                    dur_n     = '0;
                    bocina_n  = 1'b0;
                    sonando_n = 1'b0;
                end else begin
                    dur_n = dur_cnt + DW'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_generador_sonido.sv
// Scoreboard bench for generador_sonido with HALF_PERIOD=3, DUR_CYCLES=20.
// Stimulus pushes hand-written expected outputs; a monitor pops and compares.
module tb_generador_sonido;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pulso_sonido = 1'b0;
    logic bocina;
    logic sonando;

    typedef struct {
        string name;
        int    idx;
        bit    b;
        bit    s;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    generador_sonido #(
        .HALF_PERIOD(3),
        .DUR_CYCLES (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pulso_sonido(pulso_sonido),
        .bocina      (bocina),
        .sonando     (sonando)
    );

    always #5 clk = ~clk;

    function automatic string rep(string c, int n);
        string r;
        r = "";
        for (int i = 0; i < n; i++) r = {r, c};
        return r;
    endfunction

    // One entry per clock: drive on the falling edge, expect after the
    // following rising edge. An empty rst_s means reset stays low.
    task automatic run(input string name, input string rst_s,
                       input string p_s, input string b_s,
                       input string s_s);
        exp_t e;
        for (int i = 0; i < p_s.len(); i++) begin
            @(negedge clk);
            reset = (rst_s.len() > 0) ? (rst_s.getc(i) == "1") : 1'b0;
            pulso_sonido = (p_s.getc(i) == "1");
            e.name = name;
            e.idx  = i;
            e.b    = (b_s.getc(i) == "1");
            e.s    = (s_s.getc(i) == "1");
            q.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bocina !== e.b) begin
                    failures++;
                    $display("FAIL %s[%0d] bocina=%0b expected %0b",
                             e.name, e.idx, bocina, e.b);
                end
                checks++;
                if (sonando !== e.s) begin
                    failures++;
                    $display("FAIL %s[%0d] sonando=%0b expected %0b",
                             e.name, e.idx, sonando, e.s);
                end
            end
        end
    end

    initial begin : stim
        string beep;
        int    wait_cnt;
        beep = {rep("111000", 3), "11"};

        // Reset held with trigger toggling, then quiet idle.
        run("reset", "111", "101", "000", "000");
        run("idle", "", "0000", "0000", "0000");

        // Single one-cycle pulse.
        run("single", "", {"1", rep("0", 21)},
            {beep, "00"}, {rep("1", 20), "00"});

        // Level held 8 cycles counts once.
        run("held", "", {rep("1", 8), rep("0", 14)},
            {beep, "00"}, {rep("1", 20), "00"});

        // Retrigger after 10 cycles; end coincides with a 0->1 toggle.
        run("retrig10", "", {"1", rep("0", 9), "1", rep("0", 21)},
            {rep("111000", 5), "00"}, {rep("1", 30), "00"});

        // Retrigger on the terminal cycle.
        run("retrig_term", "", {"1", rep("0", 19), "1", rep("0", 21)},
            {rep("111000", 6), "1110", "00"},
            {rep("1", 40), "00"});

        // Reset at dur_cnt=7, trigger held through release.
        run("reset_mid", {rep("0", 8), "11", rep("0", 22)},
            {rep("1", 14), rep("0", 18)},
            {"11100011", "00", beep, "00"},
            {rep("1", 8), "00", rep("1", 20), "00"});

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain queue=%0d expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
